// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage and the control unit:
// reset/NOP defaults, fetch FSM encoding and base opcodes.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction/PC buffer used when a response arrives while the
// output slot is still occupied by a stalled instruction.
module if_hold_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Flush wins over load so a redirect never leaves a wrong-path entry behind.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// presents instructions (or NOP bubbles) to decode, honouring stall and redirect.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  output logic            misaligned
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            started_q, started_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic            misaligned_q, misaligned_d;

  logic            buf_load, buf_drain, buf_flush, buf_valid;
  logic [XLEN-1:0] buf_data, buf_pc;

  if_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .flush_i (buf_flush),
    .data_i  (imem_rdata),
    .pc_i    (pc_q),
    .valid_o (buf_valid),
    .data_o  (buf_data),
    .pc_o    (buf_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    started_d    = 1'b1;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    misaligned_d = misaligned_q;
    buf_load     = 1'b0;
    buf_drain    = 1'b0;
    buf_flush    = 1'b0;

    // Consumption; a load below in the same cycle overrides it.
    if (inst_valid_q && !stall) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end

    unique case (state_q)
      FETCH_IDLE: begin
        if (started_q) state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (imem_ready) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = FETCH_REQ;
          end else if (!inst_valid_q || !stall) begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = FETCH_REQ;
          end else begin
            buf_load = 1'b1;
            state_d  = FETCH_HOLD;
          end
        end
      end
      FETCH_HOLD: begin
        if (!stall && buf_valid) begin
          inst_d       = buf_data;
          inst_pc_d    = buf_pc;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
          buf_drain    = 1'b1;
          state_d      = FETCH_REQ;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    // Redirect overrides stall and any load decided above.
    if (pc_src) begin
      pc_d         = word_align(branch_target);
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
      buf_flush    = 1'b1;
      if (branch_target[1:0] != 2'b00) misaligned_d = 1'b1;
      unique case (state_q)
        FETCH_REQ: begin
          kill_d  = imem_ready;
          state_d = imem_ready ? FETCH_WAIT : FETCH_REQ;
        end
        FETCH_WAIT: begin
          kill_d  = !imem_rvalid;
          state_d = imem_rvalid ? FETCH_REQ : FETCH_WAIT;
        end
        FETCH_HOLD: state_d = FETCH_REQ;
        default:    state_d = state_d;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      started_q    <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      started_q    <= started_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req   = (state_q == FETCH_REQ);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a vector table for the main fetch flow
// plus hand-written sequences for misalignment, PC wrap and mid-flight reset.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        stall;
    logic        pcSrc;
    logic [31:0] target;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        expReq;
    logic [31:0] expAddr;
    logic [31:0] expInst;
    logic [31:0] expPc;
    logic        expValid;
    logic        expMis;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  vec_t vecs[22];

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .misaligned    (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic ps, input logic [31:0] tg,
                              input logic rd, input logic rv, input logic [31:0] dat,
                              input logic eq, input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] ep, input logic ev, input logic em);
    vec_t v;
    v.stall = st; v.pcSrc = ps; v.target = tg; v.ready = rd; v.rvalid = rv; v.rdata = dat;
    v.expReq = eq; v.expAddr = ea; v.expInst = ei; v.expPc = ep; v.expValid = ev; v.expMis = em;
    return v;
  endfunction

  // Drive one cycle of inputs, clock it, and leave outputs settled 1ns after the edge.
  task automatic applyStimulus(input logic st, input logic ps, input logic [31:0] tg,
                               input logic rd, input logic rv, input logic [31:0] dat);
    stall         = st;
    pc_src        = ps;
    branch_target = tg;
    imem_ready    = rd;
    imem_rvalid   = rv;
    imem_rdata    = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input string field,
                          input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic eq, input logic [31:0] ea,
                             input logic [31:0] ei, input logic [31:0] ep,
                             input logic ev, input logic em);
    checkOne(name, "imem_req",   {31'd0, imem_req},   {31'd0, eq});
    checkOne(name, "imem_addr",  imem_addr,           ea);
    checkOne(name, "inst",       inst,                ei);
    checkOne(name, "inst_pc",    inst_pc,             ep);
    checkOne(name, "inst_valid", {31'd0, inst_valid}, {31'd0, ev});
    checkOne(name, "misaligned", {31'd0, misaligned}, {31'd0, em});
  endtask

  initial begin
    //               stall pcSrc target        rdy rv  rdata           req addr          inst          pc            vld mis
    vecs[0]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         NOP,          32'h0,        0, 0); // IDLE
    vecs[1]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         NOP,          32'h0,        0, 0); // first req
    vecs[2]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         NOP,          32'h0,        0, 0); // handshake
    vecs[3]  = mk(0, 0, 32'h0,         0, 1, 32'h00500093,  1, 32'h4,         32'h00500093, 32'h0,        1, 0);
    vecs[4]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h4,         32'h00500093, 32'h0,        1, 0);
    vecs[5]  = mk(1, 0, 32'h0,         0, 1, 32'h00A00113,  0, 32'h4,         32'h00500093, 32'h0,        1, 0); // to HOLD
    vecs[6]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         32'h00500093, 32'h0,        1, 0);
    vecs[7]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         32'h00500093, 32'h0,        1, 0);
    vecs[8]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         32'h00500093, 32'h0,        1, 0);
    vecs[9]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         32'h00A00113, 32'h4,        1, 0); // drain
    vecs[10] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h8,         NOP,          32'h4,        0, 0); // consumed
    vecs[11] = mk(0, 0, 32'h0,         0, 1, 32'h00300193,  1, 32'hC,         32'h00300193, 32'h8,        1, 0);
    vecs[12] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'hC,         NOP,          32'h8,        0, 0);
    vecs[13] = mk(0, 1, 32'h100,       0, 0, 32'h0,         0, 32'h100,       NOP,          32'h8,        0, 0); // redirect in WAIT
    vecs[14] = mk(0, 0, 32'h0,         0, 1, 32'hDEADBEEF,  1, 32'h100,       NOP,          32'h8,        0, 0); // killed
    vecs[15] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h100,       NOP,          32'h8,        0, 0);
    vecs[16] = mk(0, 0, 32'h0,         0, 1, 32'h00100213,  1, 32'h104,       32'h00100213, 32'h100,      1, 0);
    vecs[17] = mk(0, 1, 32'h200,       1, 0, 32'h0,         0, 32'h200,       NOP,          32'h100,      0, 0); // redirect + handshake
    vecs[18] = mk(0, 0, 32'h0,         0, 1, 32'hBADBAD00,  1, 32'h200,       NOP,          32'h100,      0, 0); // killed
    vecs[19] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h200,       NOP,          32'h100,      0, 0);
    vecs[20] = mk(0, 0, 32'h0,         0, 1, 32'h00200293,  1, 32'h204,       32'h00200293, 32'h200,      1, 0);
    vecs[21] = mk(0, 1, 32'h102,       0, 0, 32'h0,         1, 32'h100,       NOP,          32'h200,      0, 1); // misaligned

    rst = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("reset", 0, 32'h0, NOP, 32'h0, 0, 0);

    rst = 1'b1;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].pcSrc, vecs[i].target,
                    vecs[i].ready, vecs[i].rvalid, vecs[i].rdata);
      checkOutput($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                  vecs[i].expInst, vecs[i].expPc, vecs[i].expValid, vecs[i].expMis);
    end

    // Misaligned flag stays set across ten zero-wait fetches from 0x100.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
      checkOutput($sformatf("mis_hs%0d", k), 0, 32'h100 + 32'(4 * k), NOP,
                  (k == 0) ? 32'h200 : 32'h100 + 32'(4 * (k - 1)), 0, 1);
      applyStimulus(0, 0, 32'h0, 0, 1, 32'hA000_0000 + 32'(k));
      checkOutput($sformatf("mis_rv%0d", k), 1, 32'h100 + 32'(4 * (k + 1)),
                  32'hA000_0000 + 32'(k), 32'h100 + 32'(4 * k), 1, 1);
    end

    // PC wrap from the last word of the address space.
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
    checkOutput("wrap_redir", 1, 32'hFFFF_FFFC, NOP, 32'h124, 0, 1);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("wrap_hs", 0, 32'hFFFF_FFFC, NOP, 32'h124, 0, 1);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0001_3579);
    checkOutput("wrap_rv", 1, 32'h0, 32'h0001_3579, 32'hFFFF_FFFC, 1, 1);

    // Reset while a fetch is outstanding; stray responses must be ignored.
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("rst_wait", 0, 32'h0, NOP, 32'hFFFF_FFFC, 0, 1);
    rst = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("rst_mid", 0, 32'h0, NOP, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h1111_1111);
    checkOutput("rst_stray", 0, 32'h0, NOP, 32'h0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h2222_2222);
    checkOutput("idle_stray", 0, 32'h0, NOP, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("restart_req", 1, 32'h0, NOP, 32'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Owns the PC and issues word fetches to instruction memory over a request/response handshake.
- Presents one instruction at a time, with its PC, to decode/control. Bubbles are presented as NOP.
- Accepts taken-branch redirects (pc_src, branch_target) from the execute side and discards any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INST, 32'h0000_0013, encoding driven on inst when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- stall  in  1  downstream not accepting; held inst must not change.
- pc_src  in  1  taken-branch redirect, sampled each cycle.
- branch_target  in  32  redirect PC, valid when pc_src=1.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address; equals pc.
- imem_ready  in  1  memory accepts request this cycle (imem_req && imem_ready = handshake).
- imem_rvalid  in  1  single-cycle response pulse, at least 1 cycle after handshake.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- inst  out  32  instruction to control unit; NOP_INST when invalid.
- inst_pc  out  32  PC of inst.
- inst_valid  out  1  inst holds a real instruction.
- misaligned  out  1  sticky: a redirect target had [1:0]≠0.

Behaviour:
- Reset (rst=0 at posedge):
  - pc=RESET_PC, state=IDLE.
  - inst=NOP_INST, inst_pc=0, inst_valid=0.
  - imem_req=0, misaligned=0, kill=0, buffer empty.
  - Reset mid-transaction abandons the outstanding request; a late imem_rvalid in IDLE is ignored.
- States:
  - IDLE: one cycle after reset release, then -> REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready -> WAIT. Otherwise hold the request with a stable address.
  - WAIT: imem_req=0. On imem_rvalid:
    - If kill=1: drop the response, clear kill, -> REQ.
    - Else if output slot free (inst_valid=0 or stall=0): inst=imem_rdata, inst_pc=pc, inst_valid=1, pc=pc+4, -> REQ.
    - Else: store rdata in a 1-entry buffer, -> HOLD.
  - HOLD: when stall=0, move the buffer into inst/inst_pc, inst_valid=1, pc=pc+4, -> REQ.
- Consumption: inst_valid=1 and stall=0 with no new load that cycle -> inst_valid=0, inst=NOP_INST.
- stall=1: inst, inst_pc and inst_valid hold exactly.
- Redirect (pc_src=1) has priority over all but reset:
  - pc=branch_target with bits [1:0] forced to 00.
  - inst_valid=0, inst=NOP_INST, buffer discarded.
  - If branch_target[1:0]≠0: misaligned=1, held until reset.
  - Next state by current state:
    - REQ without imem_ready: -> REQ (the new pc is driven next cycle).
    - REQ with imem_ready same cycle: kill=1, -> WAIT.
    - WAIT without rvalid: kill=1, stay in WAIT.
    - WAIT with rvalid same cycle: drop the response, -> REQ.
    - HOLD: -> REQ.
- Redirect overrides stall.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Latency:
  - First imem_req is asserted 2 cycles after rst goes high.
  - With zero-wait memory (ready=1, rvalid 1 cycle after handshake), inst_valid rises 2 cycles after the request.
  - Steady state: one instruction per 2 cycles.
- At most one outstanding request at any time.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INST and RESET_PC defaults.
  - Fetch state encoding (IDLE, REQ, WAIT, HOLD).
  - XLEN=32, opcode constants reused by the control unit.
- One sub-module, if_hold_buf: 1-entry data/PC buffer with load, drain and flush.
- PC register, FSM and kill flag stay in the top.

Test Plan:
- Reset release, zero-wait memory returning 32'h00500093 at 0x0: imem_req at cycle 2 with addr 0x0; inst=32'h00500093, inst_pc=0, inst_valid=1 at cycle 4; next request addr 0x4.
- stall=1 for 5 cycles while the next response arrives: inst/inst_pc unchanged, response goes to HOLD; after stall drops, the buffered inst appears next cycle with inst_pc=0x4, then a request to 0x8.
- pc_src=1, target=0x100 while in WAIT: the late response for the old PC is dropped (inst stays NOP_INST, inst_valid=0); the next imem_addr is 0x100.
- pc_src=1 in the same cycle as a REQ/imem_ready handshake: the following rvalid is discarded and a fetch to the target is issued.
- Redirect target 0x102: pc=0x100, misaligned=1 and held across 10 further fetches; cleared only by rst=0.
- pc=0xFFFF_FFFC fetched successfully: next imem_addr is 0x0. rst=0 asserted during WAIT: all outputs take reset values next edge, and a stray rvalid is ignored.
